// File: rtl/dense_layer_engine_if.sv
// Stream and weight-port bundle for dense_layer_engine: write port, input
// element stream, result stream and busy status.
interface dense_layer_engine_if #(
  parameter int unsigned N_IN  = 784,
  parameter int unsigned N_OUT = 10,
  parameter int unsigned DW    = 16
);
  localparam int unsigned AW = $clog2(N_OUT * (N_IN + 1));
  localparam int unsigned IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;

  modport slave (
    input  w_we, w_addr, w_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, busy
  );

  modport master (
    output w_we, w_addr, w_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy
  );
endinterface

// File: rtl/dense_layer_engine.sv
// Time-multiplexed fully-connected layer: one signed MAC serves every neuron.
// Define DENSE_RELU_EN to clamp negative saturated results to zero.
module dense_layer_engine #(
  parameter int unsigned N_IN  = 784,
  parameter int unsigned N_OUT = 10,
  parameter int unsigned DW    = 16,
  parameter int unsigned FRAC  = 8
) (
  input logic              clk,
  input logic              reset,
  dense_layer_engine_if.slave bus
);
  localparam int unsigned DEPTH = N_OUT * (N_IN + 1);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned ACC_W = 2 * DW + $clog2(N_IN + 1);
  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned NW    = $clog2(N_IN);
  localparam int unsigned CW    = $clog2(N_IN + 3);

  localparam logic [AW:0]              DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {LOAD, MAC, EMIT} state_t;

  state_t state_q, state_n;

  logic [NW-1:0]           cnt_q;
  logic [CW-1:0]           cyc_q;
  logic [IW-1:0]           j_q;
  logic [AW-1:0]           base_q;
  logic signed [DW-1:0]    ram_q;
  logic signed [DW-1:0]    x_q;
  logic signed [PW-1:0]    prod_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [DW-1:0]           out_data_q;
  logic [IW-1:0]           out_idx_q;
  logic                    out_last_q;
  logic                    out_valid_q;
  logic                    in_ready_q;
  logic                    busy_q;

  logic signed [DW-1:0]    mem    [DEPTH];
  logic signed [DW-1:0]    buffer [N_IN];

  logic                    in_acc_c;
  logic                    out_hs_c;
  logic                    finish_c;
  logic                    last_in_c;
  logic                    last_j_c;
  logic                    acc_en_c;
  logic [AW-1:0]           rd_addr_c;
  logic signed [PW-1:0]    mul_c;
  logic signed [PW-1:0]    bias_sh_c;
  logic signed [ACC_W-1:0] prod_ext_c;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] shr_c;
  logic [DW-1:0]           res_c;

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;

  assign last_in_c  = (cnt_q == NW'(N_IN - 1));
  assign last_j_c   = (j_q == IW'(N_OUT - 1));
  assign rd_addr_c  = base_q + AW'(cyc_q);
  assign mul_c      = PW'(ram_q) * PW'(x_q);
  assign bias_sh_c  = PW'(ram_q) <<< FRAC;
  assign prod_ext_c = ACC_W'(prod_q);
  // Cycles 2..N_IN+1 carry weight products; cycle N_IN+2 carries the bias term.
  assign acc_en_c   = (state_q == MAC) && (cyc_q >= CW'(2)) && (cyc_q <= CW'(N_IN + 1));

  // Final sum, rescale, saturate and optional rectify
  always_comb begin
    sum_c = acc_q + prod_ext_c;
    shr_c = sum_c >>> FRAC;
    if (shr_c > SAT_MAX) begin
      res_c = {1'b0, {(DW-1){1'b1}}};
    end else if (shr_c < SAT_MIN) begin
      res_c = {1'b1, {(DW-1){1'b0}}};
    end else begin
      res_c = DW'(shr_c);
    end
`ifdef DENSE_RELU_EN
    if (res_c[DW-1]) res_c = '0;
`endif
  end

  // Next-state logic
  always_comb begin
    state_n  = state_q;
    in_acc_c = 1'b0;
    out_hs_c = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      LOAD: begin
        in_acc_c = bus.in_valid;
        if (bus.in_valid && last_in_c) state_n = MAC;
      end
      MAC: begin
        finish_c = (cyc_q == CW'(N_IN + 2));
        if (finish_c) state_n = EMIT;
      end
      EMIT: begin
        out_hs_c = bus.out_ready;
        if (bus.out_ready) state_n = last_j_c ? LOAD : MAC;
      end
      default: state_n = LOAD;
    endcase
  end

  // State, control counters, MAC pipeline and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      cyc_q       <= '0;
      j_q         <= '0;
      base_q      <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      in_ready_q  <= (state_n == LOAD);
      busy_q      <= (state_n != LOAD);
      out_valid_q <= (state_n == EMIT);

      if (in_acc_c) cnt_q <= last_in_c ? '0 : cnt_q + NW'(1);
      cyc_q <= (state_q == MAC && !finish_c) ? cyc_q + CW'(1) : '0;

      if (state_q == MAC) prod_q <= (cyc_q == CW'(N_IN + 1)) ? bias_sh_c : mul_c;
      if (acc_en_c) acc_q <= ((cyc_q == CW'(2)) ? '0 : acc_q) + prod_ext_c;

      if (finish_c) begin
        out_data_q <= res_c;
        out_idx_q  <= j_q;
        out_last_q <= last_j_c;
      end

      if (out_hs_c) begin
        out_last_q <= 1'b0;
        j_q        <= last_j_c ? '0 : j_q + IW'(1);
        base_q     <= last_j_c ? '0 : base_q + AW'(N_IN + 1);
      end
    end
  end

  // Weight RAM and input buffer: unreset storage, writes blocked while busy
  always_ff @(posedge clk) begin
    if (bus.w_we && !busy_q && ({1'b0, bus.w_addr} < DEPTH_L)) mem[bus.w_addr] <= bus.w_data;
    ram_q <= mem[rd_addr_c];
    if (cyc_q < CW'(N_IN)) x_q <= buffer[NW'(cyc_q)];
    if (in_acc_c) buffer[cnt_q] <= bus.in_data;
  end
endmodule

// File: doc/dense_layer_engine.md
# dense_layer_engine

Parametrised, time-multiplexed fully-connected layer: buffers one input vector, computes every output neuron with a single signed fixed-point MAC, adds a per-neuron bias, then saturates and optionally applies ReLU. It replaces the fully-parallel per-neuron datapath in the MLP top, where wide layers make a parallel array impractical. Instances chain layer to layer (out stream → next in stream). Weights and biases live in an internal RAM loaded through a simple write port.

## Interface

Parameters:
- N_IN, 784, inputs per vector (≥2)
- N_OUT, 10, output neurons (≥1)
- DW, 16, signed data/weight width
- FRAC, 8, fractional bits (Q(DW-FRAC).FRAC)

Localparams:
- AW = clog2(N_OUT*(N_IN+1))
- ACC_W = 2*DW + clog2(N_IN+1)

Ports:
- clk, in, 1, clock
- reset, in, 1, synchronous active-high reset
- w_we, in, 1, weight/bias write strobe
- w_addr, in, AW, j*(N_IN+1)+i. i<N_IN selects a weight; i=N_IN selects the bias of neuron j
- w_data, in, DW, signed Q value
- in_valid, in, 1, input element valid
- in_ready, out, 1, engine accepts input element
- in_data, in, DW, input element, sent in index order 0..N_IN-1
- out_valid, out, 1, result valid
- out_ready, in, 1, downstream accepts result
- out_data, out, DW, neuron result
- out_idx, out, clog2(N_OUT), neuron index of out_data
- out_last, out, 1, high with out_valid for neuron N_OUT-1
- busy, out, 1, high in MAC/EMIT

## Operation

- FSM states are LOAD, MAC, EMIT. Reset enters LOAD.
- **LOAD**
  - in_ready=1.
  - Each in_valid&&in_ready writes in_data to buffer[cnt] and increments cnt.
  - On the accept with cnt=N_IN-1, the next state is MAC with j=0.
- **MAC** (neuron j)
  - Reads terms i=0..N_IN-1 plus the bias from a synchronous RAM with 1-cycle latency.
  - Each product x[i]*w[j][i] is 2*DW signed and registered, then accumulated in ACC_W.
  - The bias is added as bias<<<FRAC.
  - Accumulator clears at the start of each neuron.
- **Result**
  - r = acc>>>FRAC (arithmetic shift).
  - r is clamped to [-2^(DW-1), 2^(DW-1)-1].
  - ReLU is optional; see Configuration.
  - The result is registered into out_data and the state moves to EMIT.
- **EMIT**
  - out_valid=1. out_data, out_idx and out_last stay stable until out_ready.
  - On the handshake:
    - if j<N_OUT-1, j increments and the state is MAC;
    - otherwise the state is LOAD with cnt=0.
- **Weight writes** are accepted only when busy=0. A w_we while busy=1 is ignored and leaves memory unchanged.
- **Simultaneous events**
  - A write and an input accept in the same LOAD cycle are independent; both are performed.
  - The weight RAM and input buffer have no reset. Contents persist across reset.
- **Reset mid-operation**
  - Discards the partial vector and accumulator. cnt=0, j=0, state LOAD.

## Timing

- Reset values: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0.
- in_ready drops the cycle after the final input accept. busy rises in the same cycle.
- Per-neuron latency: out_valid rises exactly N_IN+3 cycles after MAC entry. That is N_IN+1 reads, plus 1 RAM latency, plus 1 product register.
- With out_ready held high, each neuron costs N_IN+4 cycles, with one EMIT cycle.
- After the out_last handshake, in_ready=1 and busy=0 on the next cycle.
- Whole-vector latency is N_IN accept cycles + N_OUT*(N_IN+4) cycles, assuming no backpressure.
- in_ready is a pure function of state, with no combinational path from in_valid or out_ready.
- out_valid never drops without a handshake, except on reset.

## Configuration

- DENSE_RELU_EN defined: the result after saturation is forced to 0 when negative. Positive values pass unchanged.
- DENSE_RELU_EN undefined: linear output, saturated only. Used for the final (logit) layer.

## Test plan

Use N_IN=4, N_OUT=3, DW=16, FRAC=8.

1. Reset for 2 cycles, then idle → in_ready=1, busy=0, out_valid=0, out_data=0x0000, out_idx=0, out_last=0.
2. All weights 0x0100, biases 0, inputs 0x0100,0x0200,0x0300,0x0400 → three results 0x0A00 with idx 0,1,2. out_last only on idx 2. First out_valid arrives 7 cycles after busy rises.
3. Neuron 1 weights 0xFF00 (-1.0), bias 0x0080 (+0.5), same inputs → raw result -9.5.
   - With DENSE_RELU_EN: out_data=0x0000.
   - Without: 0xF680.
   - Neurons 0 and 2 are unchanged at 0x0A00.
4. All weights and inputs 0x7FFF → out_data=0x7FFF. With weights 0x8000 and without the macro → 0x8000.
5. Hold out_ready=0 for 20 cycles on idx 0, and attempt a w_we during busy → out_valid, out_data and out_idx stay stable. The later readback of the same vector shows memory unchanged.
6. Assert reset 3 cycles into MAC of neuron 1, then resend the vector → no stale output. The first result is idx 0 with the correct value from scenario 2. Weights are retained.
